c1541_iec_hub: RTL

//  Multi-drive serial-bus hub and drive timing generator for the 1541 subsystem.
//  - Combines the host's IEC ATN/CLK/DATA lines with the CLK/DATA outputs of NDRIVES drive cores as a wired-AND bus.
//  - Returns the raw bus level to the host.
//  - Feeds each drive a synchronised, glitch-filtered copy of the bus.
//  - Generates per-drive phase-staggered 1 MHz phi2 rising/falling enables, so several drive CPUs share clk32.

---
 rtl/c1541_iec_hub_if.sv | 32 +++
 rtl/c1541_iec_hub.sv | 127 ++++++++++++
 2 files changed

// File: rtl/c1541_iec_hub_if.sv
// IEC hub bus bundle: host lines, per-drive outputs/enables, filtered bus and phi2 enables.
// The hub takes the slave modport; the host/drive side takes master.
interface c1541_iec_hub_if #(
  parameter int NDRIVES = 4
);
  logic               host_atn;
  logic               host_clk;
  logic               host_data;
  logic [NDRIVES-1:0] drv_clk_out;
  logic [NDRIVES-1:0] drv_data_out;
  logic [NDRIVES-1:0] drv_en;
  logic               host_clk_in;
  logic               host_data_in;
  logic               bus_atn;
  logic               bus_clk;
  logic               bus_data;
  logic [NDRIVES-1:0] p2_h_r;
  logic [NDRIVES-1:0] p2_h_f;
  logic               bus_stuck;

  modport master (
    output host_atn, host_clk, host_data, drv_clk_out, drv_data_out, drv_en,
    input  host_clk_in, host_data_in, bus_atn, bus_clk, bus_data,
           p2_h_r, p2_h_f, bus_stuck
  );

  modport slave (
    input  host_atn, host_clk, host_data, drv_clk_out, drv_data_out, drv_en,
    output host_clk_in, host_data_in, bus_atn, bus_clk, bus_data,
           p2_h_r, p2_h_f, bus_stuck
  );
endinterface

// File: rtl/c1541_iec_hub.sv
// Multi-drive IEC wired-AND hub, bus glitch filter and phase-staggered phi2 enables.
// Optional stuck-bus watchdog enabled by defining IEC_HUB_STUCK_EN.
module c1541_iec_hub #(
  parameter int NDRIVES    = 4,
  parameter int DIV        = 32,
  parameter int PHASE_STEP = 8,
  parameter int FILT_LEN   = 1,
  parameter int STUCK_LOG2 = 20
) (
  input logic             clk32,
  input logic             reset_n,
  c1541_iec_hub_if.slave  bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  function automatic logic [CW-1:0] off_r(input int unsigned i);
    return CW'((i * PHASE_STEP) % DIV);
  endfunction

  function automatic logic [CW-1:0] off_f(input int unsigned i);
    return CW'((i * PHASE_STEP + DIV / 2) % DIV);
  endfunction

  // Wired-AND: a disabled drive is treated as released.
  logic wclk, wdata;
  assign wclk  = bus.host_clk  & (&(bus.drv_clk_out  | ~bus.drv_en));
  assign wdata = bus.host_data & (&(bus.drv_data_out | ~bus.drv_en));
  assign bus.host_clk_in  = wclk;
  assign bus.host_data_in = wdata;

  // Phase counter and per-drive enables
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NDRIVES-1:0] p2r_q, p2r_d, p2f_q, p2f_d;

  always_comb begin
    cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
    p2r_d = '0;
    p2f_d = '0;
    for (int unsigned i = 0; i < NDRIVES; i++) begin
      p2r_d[i] = bus.drv_en[i] && (cnt_q == off_r(i));
      p2f_d[i] = bus.drv_en[i] && (cnt_q == off_f(i));
    end
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      cnt_q <= '0;
      p2r_q <= '0;
      p2f_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      p2r_q <= p2r_d;
      p2f_q <= p2f_d;
    end
  end

  assign bus.p2_h_r = p2r_q;
  assign bus.p2_h_f = p2f_q;

  // Line filter, index 2=ATN 1=CLK 0=DATA. The stability counter only runs
  // while the synced level disagrees with the filtered output.
  logic [2:0] raw, s1_q, s2_q, filt_q, filt_d;
  logic [3:0] fcnt_q [3];
  logic [3:0] fcnt_d [3];

  assign raw = {bus.host_atn, wclk, wdata};

  always_comb begin
    filt_d = filt_q;
    for (int unsigned l = 0; l < 3; l++) begin
      fcnt_d[l] = '0;
      if (s2_q[l] != filt_q[l]) begin
        if (({1'b0, fcnt_q[l]} + 5'd1) >= 5'(FILT_LEN)) begin
          filt_d[l] = s2_q[l];
        end else begin
          fcnt_d[l] = fcnt_q[l] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      s1_q   <= '1;
      s2_q   <= '1;
      filt_q <= '1;
      for (int unsigned l = 0; l < 3; l++) fcnt_q[l] <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      for (int unsigned l = 0; l < 3; l++) fcnt_q[l] <= fcnt_d[l];
    end
  end

  assign bus.bus_atn  = filt_q[2];
  assign bus.bus_clk  = filt_q[1];
  assign bus.bus_data = filt_q[0];

`ifdef IEC_HUB_STUCK_EN
  localparam logic [STUCK_LOG2:0] TH = {1'b1, {STUCK_LOG2{1'b0}}};
  logic [STUCK_LOG2:0] wd_q, wd_d;
  logic                stuck_q, stuck_d;
  logic                hold;

  always_comb begin
    hold    = filt_q[2] && (!filt_q[1] || !filt_q[0]);
    wd_d    = '0;
    if (hold) wd_d = (wd_q == TH) ? wd_q : wd_q + 1'b1;
    stuck_d = stuck_q || (wd_d == TH);
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      wd_q    <= '0;
      stuck_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stuck_q <= stuck_d;
    end
  end

  assign bus.bus_stuck = stuck_q;
`else
  assign bus.bus_stuck = 1'b0;
`endif
endmodule
